// File: rtl/alu_req_sched_if.sv
// -----------------------------------------------------------------------------
// alu_req_sched_if
// Command and response bundle for alu_req_sched.
//   r0_* / r1_* : per-requester command channel (valid/ready, op, a, b, cnt)
//   rsp_*       : shared response channel (valid/ready, id, r, cf)
// Modports:
//   master : requester/consumer side (drives commands and rsp_ready)
//   slave  : scheduler side (drives readies and the response)
// -----------------------------------------------------------------------------
interface alu_req_sched_if #(
  parameter int W     = 4,
  parameter int CNT_W = 2
);
  logic             r0_valid;
  logic             r0_ready;
  logic [1:0]       r0_op;
  logic [W-1:0]     r0_a;
  logic [W-1:0]     r0_b;
  logic [CNT_W-1:0] r0_cnt;

  logic             r1_valid;
  logic             r1_ready;
  logic [1:0]       r1_op;
  logic [W-1:0]     r1_a;
  logic [W-1:0]     r1_b;
  logic [CNT_W-1:0] r1_cnt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [W-1:0]     rsp_r;
  logic             rsp_cf;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b, r0_cnt,
    output r1_valid, r1_op, r1_a, r1_b, r1_cnt,
    output rsp_ready,
    input  r0_ready, r1_ready,
    input  rsp_valid, rsp_id, rsp_r, rsp_cf
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b, r0_cnt,
    input  r1_valid, r1_op, r1_a, r1_b, r1_cnt,
    input  rsp_ready,
    output r0_ready, r1_ready,
    output rsp_valid, rsp_id, rsp_r, rsp_cf
  );
endinterface

// File: rtl/alu_req_sched.sv
// -----------------------------------------------------------------------------
// alu_req_sched
// Shares one external W-bit ALU between two requesters. Each accepted command
// runs cnt+1 ALU iterations with the result fed back as operand A and B held;
// the final result and a sticky carry are returned on the shared response
// channel tagged with the requester id. Arbitration is round-robin.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   bus         : alu_req_sched_if.slave (both command channels + response)
//   busy        : high whenever the scheduler is not idle
//   alu_op/a/b  : drive the external ALU (zero outside execution)
//   alu_r/cf    : combinational result and carry from the external ALU
// -----------------------------------------------------------------------------
module alu_req_sched #(
  parameter int W     = 4,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_req_sched_if.slave       bus,
  output logic                 busy,
  output logic [1:0]           alu_op,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  input  logic [W-1:0]         alu_r,
  input  logic                 alu_cf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             id_reg;
  logic [1:0]       op_reg;
  logic [W-1:0]     acc;
  logic [W-1:0]     b_reg;
  logic [CNT_W-1:0] iter;
  logic             cf_acc;

  logic             pref;
  logic             pref_valid;
  logic             other_valid;
  logic             gnt_valid;
  logic             gnt_id;
  logic             take;
  logic [1:0]       sel_op;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic [CNT_W-1:0] sel_cnt;

  // Round-robin: the requester that was not served last wins a tie.
  assign pref        = ~last_grant;
  assign pref_valid  = pref ? bus.r1_valid : bus.r0_valid;
  assign other_valid = pref ? bus.r0_valid : bus.r1_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (pref_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = pref;
    end else if (other_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ~pref;
    end
  end

  // Readies are held low while reset is asserted so nothing is accepted
  // until the block is released.
  assign take         = (state == IDLE) && !reset && gnt_valid;
  assign bus.r0_ready = take && !gnt_id;
  assign bus.r1_ready = take &&  gnt_id;

  assign sel_op  = gnt_id ? bus.r1_op  : bus.r0_op;
  assign sel_a   = gnt_id ? bus.r1_a   : bus.r0_a;
  assign sel_b   = gnt_id ? bus.r1_b   : bus.r0_b;
  assign sel_cnt = gnt_id ? bus.r1_cnt : bus.r0_cnt;

  // The ALU sees the working operands only while iterating; it is parked at
  // add 0,0 otherwise.
  always_comb begin
    alu_op = 2'b00;
    alu_a  = '0;
    alu_b  = '0;
    if (state == EXEC) begin
      alu_op = op_reg;
      alu_a  = acc;
      alu_b  = b_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too, so a command cut short
      // by reset leaves no stale operands behind.
      state         <= IDLE;
      last_grant    <= 1'b1;
      id_reg        <= 1'b0;
      op_reg        <= 2'b00;
      acc           <= '0;
      b_reg         <= '0;
      iter          <= '0;
      cf_acc        <= 1'b0;
      busy          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_r     <= '0;
      bus.rsp_cf    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      case (state)
        IDLE: begin
          if (take) begin
            op_reg     <= sel_op;
            b_reg      <= sel_b;
            iter       <= sel_cnt;
            acc        <= sel_a;
            cf_acc     <= 1'b0;
            id_reg     <= gnt_id;
            last_grant <= gnt_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          acc    <= alu_r;
          cf_acc <= cf_acc | alu_cf;
          if (iter == '0) begin
            bus.rsp_r     <= alu_r;
            bus.rsp_cf    <= cf_acc | alu_cf;
            bus.rsp_id    <= id_reg;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            // Only decremented while non-zero, so the count never wraps.
            iter <= iter - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_req_sched
// Self-checking bench for alu_req_sched. Provides the external ALU, a
// transaction-level model of the scheduler (occupancy flag, round-robin
// pointer, per-command result precomputed by looping the ALU function), a
// single per-cycle compare process, directed scenarios with literal
// expectations, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_req_sched;
  localparam int W     = 4;
  localparam int CNT_W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         busy;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_r;
  logic         alu_cf;

  alu_req_sched_if #(.W(W), .CNT_W(CNT_W)) bus ();

  alu_req_sched #(.W(W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy   (busy),
    .alu_op (alu_op),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_r  (alu_r),
    .alu_cf (alu_cf)
  );

  always #5 clk = ~clk;

  // External ALU: returns {cf, r}. Sub reports borrow as cf.
  function automatic logic [W:0] alu_f(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a << b[1:0]};
      default: return {1'b0, ~(a & b)};
    endcase
  endfunction

  assign {alu_cf, alu_r} = alu_f(alu_op, alu_a, alu_b);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_free = 1'b1;
  bit           m_last = 1'b1;
  int           cyc = 0;
  bit           cur_id;
  logic [1:0]   cur_op;
  logic [W-1:0] cur_b;
  int           cur_cnt;
  int           cur_acc;
  logic [W-1:0] cur_seq [0:3];
  logic [W-1:0] cur_r;
  bit           cur_cf;
  bit           first_seen;

  int           grant_log[$];
  int           rsp_r_log[$];
  int           rsp_id_log[$];
  int           rsp_count = 0;
  int           last_lat  = 0;
  logic [W-1:0] last_r;
  bit           last_cf;
  bit           last_id;

  always @(negedge clk) begin
    bit           gv;
    bit           gnt;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   t;
    int           cnt;
    int           k;
    cyc++;
    if (reset) begin
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_r", bus.rsp_r, 0);
      check("rst_rsp_cf", bus.rsp_cf, 0);
      check("rst_r0_ready", bus.r0_ready, 0);
      check("rst_r1_ready", bus.r1_ready, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      m_free = 1'b1;
      m_last = 1'b1;
    end else if (m_free) begin
      gv  = 1'b0;
      gnt = 1'b0;
      if ((!m_last) ? bus.r1_valid : bus.r0_valid) begin
        gv = 1'b1; gnt = !m_last;
      end else if (m_last ? bus.r1_valid : bus.r0_valid) begin
        gv = 1'b1; gnt = m_last;
      end
      check("idle_busy", busy, 0);
      check("idle_rsp_valid", bus.rsp_valid, 0);
      check("idle_r0_ready", bus.r0_ready, gv && !gnt);
      check("idle_r1_ready", bus.r1_ready, gv && gnt);
      check("idle_alu_op", alu_op, 0);
      check("idle_alu_a", alu_a, 0);
      check("idle_alu_b", alu_b, 0);
      if (gv) begin
        op  = gnt ? bus.r1_op : bus.r0_op;
        a   = gnt ? bus.r1_a  : bus.r0_a;
        b   = gnt ? bus.r1_b  : bus.r0_b;
        cnt = int'(gnt ? bus.r1_cnt : bus.r0_cnt);
        cur_id = gnt; cur_op = op; cur_b = b; cur_cnt = cnt; cur_acc = cyc;
        cur_cf = 1'b0;
        for (int i = 0; i <= cnt; i++) begin
          cur_seq[i] = a;
          t = alu_f(op, a, b);
          cur_cf = cur_cf | t[W];
          a = t[W-1:0];
        end
        cur_r = a;
        m_free = 1'b0;
        m_last = gnt;
        first_seen = 1'b0;
        grant_log.push_back(int'(gnt));
      end
    end else begin
      k = cyc - cur_acc;
      check("busy_busy", busy, 1);
      check("busy_r0_ready", bus.r0_ready, 0);
      check("busy_r1_ready", bus.r1_ready, 0);
      if (bus.rsp_valid && !first_seen) begin
        first_seen = 1'b1;
        last_lat = k;
      end
      if (k <= cur_cnt + 1) begin
        check("exec_rsp_valid", bus.rsp_valid, 0);
        check("exec_alu_op", alu_op, cur_op);
        check("exec_alu_a", alu_a, cur_seq[k-1]);
        check("exec_alu_b", alu_b, cur_b);
      end else begin
        check("resp_rsp_valid", bus.rsp_valid, 1);
        check("resp_rsp_id", bus.rsp_id, cur_id);
        check("resp_rsp_r", bus.rsp_r, cur_r);
        check("resp_rsp_cf", bus.rsp_cf, cur_cf);
        check("resp_alu_op", alu_op, 0);
        check("resp_alu_a", alu_a, 0);
        check("resp_alu_b", alu_b, 0);
        if (bus.rsp_ready) m_free = 1'b1;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_r  = bus.rsp_r;
        last_cf = bus.rsp_cf;
        last_id = bus.rsp_id;
        rsp_r_log.push_back(int'(bus.rsp_r));
        rsp_id_log.push_back(int'(bus.rsp_id));
        rsp_count++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(bit id, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                      logic [CNT_W-1:0] cnt);
    bit ok;
    if (!id) begin
      bus.r0_op = op; bus.r0_a = a; bus.r0_b = b; bus.r0_cnt = cnt; bus.r0_valid = 1'b1;
    end else begin
      bus.r1_op = op; bus.r1_a = a; bus.r1_b = b; bus.r1_cnt = cnt; bus.r1_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id ? bus.r1_ready : bus.r0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_handshake", ok, 1);
    @(posedge clk); #1;
    if (!id) bus.r0_valid = 1'b0;
    else     bus.r1_valid = 1'b0;
  endtask

  task automatic wait_rsp(int n0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_count > n0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rsp_timeout", ok, 1);
  endtask

  task automatic wait_grants(int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (grant_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_timeout", ok, 1);
  endtask

  function automatic int log_at(int q[$], int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    int gl;
    bit ok;
    bus.r0_valid = 0; bus.r0_op = 0; bus.r0_a = 0; bus.r0_b = 0; bus.r0_cnt = 0;
    bus.r1_valid = 0; bus.r1_op = 0; bus.r1_a = 0; bus.r1_b = 0; bus.r1_cnt = 0;
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single add, cnt=0
    n0 = rsp_count;
    send(0, 2'b00, 4'd5, 4'd3, 2'd0);
    wait_rsp(n0);
    check("t1_r", last_r, 8);
    check("t1_cf", last_cf, 0);
    check("t1_id", last_id, 0);
    check("t1_lat", last_lat, 2);

    // r1 repeated add, then r0 add with wrap
    n0 = rsp_count;
    send(1, 2'b00, 4'd1, 4'd3, 2'd2);
    wait_rsp(n0);
    check("t2_r", last_r, 10);
    check("t2_cf", last_cf, 0);
    check("t2_id", last_id, 1);
    check("t2_lat", last_lat, 4);
    n0 = rsp_count;
    send(0, 2'b00, 4'd9, 4'd4, 2'd1);
    wait_rsp(n0);
    check("t3_r", last_r, 1);
    check("t3_cf", last_cf, 1);
    check("t3_id", last_id, 0);
    check("t3_lat", last_lat, 3);

    // Max count: exactly four EXEC cycles with alu_a 0,1,2,3
    n0 = rsp_count;
    send(0, 2'b00, 4'd0, 4'd1, 2'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("max_alu_a", alu_a, i);
      check("max_no_rsp", bus.rsp_valid, 0);
    end
    @(negedge clk);
    check("max_rsp_at_5", bus.rsp_valid, 1);
    wait_rsp(n0);
    check("max_r", last_r, 4);
    check("max_cf", last_cf, 0);

    // Response backpressure: sub 2-5-5 -> 8 with sticky borrow
    bus.rsp_ready = 1'b0;
    n0 = rsp_count;
    send(1, 2'b01, 4'd2, 4'd5, 2'd1);
    bus.r0_op = 2'b11; bus.r0_a = 4'd6; bus.r0_b = 4'd3; bus.r0_cnt = 2'd0;
    bus.r0_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_rsp_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_r", bus.rsp_r, 8);
      check("bp_cf", bus.rsp_cf, 1);
      check("bp_id", bus.rsp_id, 1);
      check("bp_r0_ready", bus.r0_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_alu_op", alu_op, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_c6", bus.rsp_valid, 1);
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_valid", bus.rsp_valid, 0);
    check("bp_idle_r0_ready", bus.r0_ready, 1);
    @(posedge clk); #1 bus.r0_valid = 1'b0;
    wait_rsp(n0 + 1);
    check("bp_next_r", last_r, 13);
    check("bp_next_id", last_id, 0);

    // Reset in the second EXEC cycle of a cnt=3 command
    send(0, 2'b00, 4'd1, 4'd1, 2'd3);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus.rsp_valid, 0);
    n0 = rsp_count;
    bus.r0_op = 2'b00; bus.r0_a = 4'd7; bus.r0_b = 4'd2; bus.r0_cnt = 2'd0;
    bus.r1_op = 2'b00; bus.r1_a = 4'd3; bus.r1_b = 4'd3; bus.r1_cnt = 2'd0;
    bus.r0_valid = 1'b1;
    bus.r1_valid = 1'b1;
    @(posedge clk); #1;
    gl = grant_log.size();
    reset = 1'b0;
    // Both valid continuously from release: grants alternate
    wait_grants(gl + 4);
    check("rr_g0", log_at(grant_log, gl), 0);
    check("rr_g1", log_at(grant_log, gl + 1), 1);
    check("rr_g2", log_at(grant_log, gl + 2), 0);
    check("rr_g3", log_at(grant_log, gl + 3), 1);
    wait_rsp(n0 + 1);
    check("post_rst_first_r", log_at(rsp_r_log, n0), 9);
    check("post_rst_first_id", log_at(rsp_id_log, n0), 0);
    check("post_rst_second_r", log_at(rsp_r_log, n0 + 1), 6);

    // Same start, r1 withdraws after its first grant
    reset = 1'b1;
    @(posedge clk); #1;
    gl = grant_log.size();
    reset = 1'b0;
    wait_grants(gl + 2);
    bus.r1_valid = 1'b0;
    wait_grants(gl + 4);
    check("rr2_g0", log_at(grant_log, gl), 0);
    check("rr2_g1", log_at(grant_log, gl + 1), 1);
    check("rr2_g2", log_at(grant_log, gl + 2), 0);
    check("rr2_g3", log_at(grant_log, gl + 3), 0);
    bus.r0_valid = 1'b0;

    // Randomized traffic; inputs also change while not ready
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.r0_valid  = ($urandom_range(0, 99) < 60);
      bus.r1_valid  = ($urandom_range(0, 99) < 60);
      bus.r0_op     = 2'($urandom);
      bus.r0_a      = W'($urandom);
      bus.r0_b      = W'($urandom);
      bus.r0_cnt    = CNT_W'($urandom);
      bus.r1_op     = 2'($urandom);
      bus.r1_a      = W'($urandom);
      bus.r1_b      = W'($urandom);
      bus.r1_cnt    = CNT_W'($urandom);
      bus.rsp_ready = ($urandom_range(0, 99) < 75);
    end
    bus.r0_valid  = 1'b0;
    bus.r1_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("end_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
